// File: rtl/parking_entry_arbiter.sv
// parking_entry_arbiter
//   Shares one PIN checker and one gate between two entry lanes. When both
//   lanes request at once, the lane that was not granted last wins. The
//   granted lane's 16-bit code is compared against PASSWORD. A correct code
//   opens the gate, and the vehicle passing the gate sensor is counted into
//   the lot. MAX_TRIES consecutive wrong codes lock the checker in BLOCKED
//   until a correct code arrives.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous reset, active low
//   vehicle_arrival bit i: a vehicle is waiting at lane i
//   code0 / code1   keypad code of lane 0 / lane 1
//   code_ack        bit i: lane i submits its code this cycle (pulse)
//   vehicle_in      a vehicle passed the gate sensor
//   vehicle_left    a vehicle exited the lot (pulse)
//   grant           one-hot lane that owns the checker, 0 when idle
//   gate_open       gate actuator
//   wrong_pin       one-cycle pulse for each rejected code
//   block_alarm     high while BLOCKED
//   lot_full        occupancy == CAPACITY (decoded from the register)
//   occupancy       number of vehicles inside
module parking_entry_arbiter #(
  parameter logic [15:0] PASSWORD  = 16'h5990,
  parameter int          CAPACITY  = 8,
  parameter int          MAX_TRIES = 3,
  parameter int          CW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    vehicle_arrival,
  input  logic [15:0]   code0,
  input  logic [15:0]   code1,
  input  logic [1:0]    code_ack,
  input  logic          vehicle_in,
  input  logic          vehicle_left,
  output logic [1:0]    grant,
  output logic          gate_open,
  output logic          wrong_pin,
  output logic          block_alarm,
  output logic          lot_full,
  output logic [CW-1:0] occupancy
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    BLOCKED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          gate_open_q, gate_open_d;
  logic          wrong_pin_q, wrong_pin_d;
  logic          block_alarm_q, block_alarm_d;
  logic [CW-1:0] occupancy_q, occupancy_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          rr_q, rr_d;  // lane granted most recently

  logic          full;
  logic          new_lane;    // lane chosen in IDLE
  logic          cur_lane;    // lane currently holding the grant
  logic          cur_ack;
  logic          cur_match;
  logic [TW-1:0] tries_sat;   // tries_q + 1, saturating at MAX_TRIES
  logic          counted_in;

  assign full      = (occupancy_q == CW'(CAPACITY));
  assign new_lane  = (vehicle_arrival == 2'b11) ? ~rr_q : vehicle_arrival[1];
  assign cur_lane  = grant_q[1];
  assign cur_ack   = code_ack[cur_lane];
  assign cur_match = ((cur_lane ? code1 : code0) == PASSWORD);
  assign tries_sat = (tries_q == TW'(MAX_TRIES)) ? tries_q : tries_q + TW'(1);
  assign counted_in = (state_q == OPEN) && vehicle_in;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    wrong_pin_d = 1'b0;
    tries_d     = tries_q;
    rr_d        = rr_q;

    case (state_q)
      IDLE: begin
        if (!full && (vehicle_arrival != 2'b00)) begin
          grant_d = new_lane ? 2'b10 : 2'b01;
          rr_d    = new_lane;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (cur_ack) begin
          if (cur_match) begin
            state_d = OPEN;
            tries_d = '0;
          end else begin
            wrong_pin_d = 1'b1;
            tries_d     = tries_sat;
            if (tries_sat == TW'(MAX_TRIES)) state_d = BLOCKED;
          end
        end else if (!vehicle_arrival[cur_lane]) begin
          // Vehicle gave up before entering a code: release the checker.
          state_d = IDLE;
          grant_d = 2'b00;
          tries_d = '0;
        end
      end
      OPEN: begin
        if (vehicle_in) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      BLOCKED: begin
        // Only a correct code leaves BLOCKED; an arrival drop does not.
        if (cur_ack) begin
          if (cur_match) begin
            state_d = OPEN;
            tries_d = '0;
          end else begin
            wrong_pin_d = 1'b1;
            tries_d     = tries_sat;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase

    gate_open_d   = (state_d == OPEN);
    block_alarm_d = (state_d == BLOCKED);

    // Simultaneous entry and exit cancel out; exit saturates at zero.
    occupancy_d = occupancy_q;
    if (counted_in && !vehicle_left) begin
      occupancy_d = occupancy_q + CW'(1);
    end else if (!counted_in && vehicle_left && (occupancy_q != '0)) begin
      occupancy_d = occupancy_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      gate_open_q   <= 1'b0;
      wrong_pin_q   <= 1'b0;
      block_alarm_q <= 1'b0;
      occupancy_q   <= '0;
      tries_q       <= '0;
      rr_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gate_open_q   <= gate_open_d;
      wrong_pin_q   <= wrong_pin_d;
      block_alarm_q <= block_alarm_d;
      occupancy_q   <= occupancy_d;
      tries_q       <= tries_d;
      rr_q          <= rr_d;
    end
  end

  assign grant       = grant_q;
  assign gate_open   = gate_open_q;
  assign wrong_pin   = wrong_pin_q;
  assign block_alarm = block_alarm_q;
  assign lot_full    = full;
  assign occupancy   = occupancy_q;

endmodule

// File: tb/tb_parking_entry_arbiter.sv
// Directed testbench for parking_entry_arbiter.
module tb_parking_entry_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  vehicle_arrival;
  logic [15:0] code0;
  logic [15:0] code1;
  logic [1:0]  code_ack;
  logic        vehicle_in;
  logic        vehicle_left;
  logic [1:0]  grant;
  logic        gate_open;
  logic        wrong_pin;
  logic        block_alarm;
  logic        lot_full;
  logic [3:0]  occupancy;

  int checks;
  int failures;

  parking_entry_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .vehicle_arrival (vehicle_arrival),
    .code0           (code0),
    .code1           (code1),
    .code_ack        (code_ack),
    .vehicle_in      (vehicle_in),
    .vehicle_left    (vehicle_left),
    .grant           (grant),
    .gate_open       (gate_open),
    .wrong_pin       (wrong_pin),
    .block_alarm     (block_alarm),
    .lot_full        (lot_full),
    .occupancy       (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    vehicle_arrival = 2'b00;
    code0 = 16'h0000;
    code1 = 16'h0000;
    code_ack = 2'b00;
    vehicle_in = 1'b0;
    vehicle_left = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Admit one vehicle through the given lane with the correct code.
  task automatic admit(input int lane);
    vehicle_arrival = (lane == 1) ? 2'b10 : 2'b01;
    code0 = 16'h5990;
    code1 = 16'h5990;
    tick();
    code_ack = vehicle_arrival;
    tick();
    code_ack = 2'b00;
    vehicle_in = 1'b1;
    tick();
    vehicle_in = 1'b0;
    vehicle_arrival = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, gate_open, wrong_pin, block_alarm, lot_full, occupancy} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: got grant=%b gate=%b wp=%b alarm=%b full=%b occ=%0d, want all 0",
               grant, gate_open, wrong_pin, block_alarm, lot_full, occupancy);
    end
  endtask

  task automatic test_single_entry();
    do_reset();
    vehicle_arrival = 2'b01;
    code0 = 16'h5990;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL single_grant: got %b want 01", grant);
    end
    code_ack = 2'b01;
    tick();
    code_ack = 2'b00;
    checks++;
    if (gate_open !== 1'b1 || wrong_pin !== 1'b0) begin
      failures++;
      $display("FAIL single_open: got gate=%b wp=%b want gate=1 wp=0", gate_open, wrong_pin);
    end
    vehicle_in = 1'b1;
    tick();
    vehicle_in = 1'b0;
    vehicle_arrival = 2'b00;
    checks++;
    if (occupancy !== 4'd1 || gate_open !== 1'b0 || grant !== 2'b00) begin
      failures++;
      $display("FAIL single_pass: got occ=%0d gate=%b grant=%b want occ=1 gate=0 grant=00",
               occupancy, gate_open, grant);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_grant [3];
    exp_grant[0] = 2'b01;
    exp_grant[1] = 2'b10;
    exp_grant[2] = 2'b01;
    do_reset();
    code0 = 16'h5990;
    code1 = 16'h5990;
    vehicle_arrival = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== exp_grant[i]) begin
        failures++;
        $display("FAIL rr_tie%0d: got grant=%b want %b", i, grant, exp_grant[i]);
      end
      code_ack = exp_grant[i];
      tick();
      code_ack = 2'b00;
      vehicle_in = 1'b1;
      tick();
      vehicle_in = 1'b0;
    end
    vehicle_arrival = 2'b00;
    checks++;
    if (occupancy !== 4'd3) begin
      failures++;
      $display("FAIL rr_occ: got %0d want 3", occupancy);
    end
  endtask

  task automatic test_block();
    int pulses;
    do_reset();
    pulses = 0;
    vehicle_arrival = 2'b01;
    code0 = 16'h1234;
    tick();
    for (int i = 0; i < 3; i++) begin
      code_ack = 2'b01;
      tick();
      code_ack = 2'b00;
      if (wrong_pin === 1'b1) pulses++;
      checks++;
      if (block_alarm !== (i == 2)) begin
        failures++;
        $display("FAIL block_alarm_try%0d: got %b want %b", i, block_alarm, (i == 2));
      end
      tick();
      checks++;
      if (wrong_pin !== 1'b0) begin
        failures++;
        $display("FAIL wrong_pin_width_try%0d: got %b want 0", i, wrong_pin);
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL wrong_pin_count: got %0d want 3", pulses);
    end
    // Arrival drop must not leave BLOCKED.
    vehicle_arrival = 2'b00;
    tick();
    tick();
    checks++;
    if (block_alarm !== 1'b1 || grant !== 2'b01) begin
      failures++;
      $display("FAIL block_hold: got alarm=%b grant=%b want alarm=1 grant=01", block_alarm, grant);
    end
    vehicle_arrival = 2'b01;
    code_ack = 2'b01;
    tick();
    code_ack = 2'b00;
    checks++;
    if (wrong_pin !== 1'b1 || block_alarm !== 1'b1) begin
      failures++;
      $display("FAIL block_wrong_again: got wp=%b alarm=%b want wp=1 alarm=1", wrong_pin, block_alarm);
    end
    code0 = 16'h5990;
    code_ack = 2'b01;
    tick();
    code_ack = 2'b00;
    checks++;
    if (block_alarm !== 1'b0 || gate_open !== 1'b1) begin
      failures++;
      $display("FAIL unblock: got alarm=%b gate=%b want alarm=0 gate=1", block_alarm, gate_open);
    end
    vehicle_in = 1'b1;
    tick();
    vehicle_in = 1'b0;
    vehicle_arrival = 2'b00;
  endtask

  task automatic test_drop();
    do_reset();
    vehicle_arrival = 2'b10;
    tick();
    checks++;
    if (grant !== 2'b10) begin
      failures++;
      $display("FAIL drop_grant: got %b want 10", grant);
    end
    vehicle_arrival = 2'b00;
    tick();
    checks++;
    if (grant !== 2'b00 || gate_open !== 1'b0) begin
      failures++;
      $display("FAIL drop_release: got grant=%b gate=%b want 00/0", grant, gate_open);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) admit(i % 2);
    checks++;
    if (occupancy !== 4'd8 || lot_full !== 1'b1) begin
      failures++;
      $display("FAIL full_occ: got occ=%0d full=%b want 8/1", occupancy, lot_full);
    end
    vehicle_arrival = 2'b01;
    code0 = 16'h5990;
    tick();
    tick();
    checks++;
    if (grant !== 2'b00) begin
      failures++;
      $display("FAIL full_no_grant: got %b want 00", grant);
    end
    vehicle_left = 1'b1;
    tick();
    vehicle_left = 1'b0;
    checks++;
    if (occupancy !== 4'd7 || lot_full !== 1'b0 || grant !== 2'b00) begin
      failures++;
      $display("FAIL full_left: got occ=%0d full=%b grant=%b want 7/0/00", occupancy, lot_full, grant);
    end
    tick();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL full_regrant: got %b want 01", grant);
    end
    vehicle_arrival = 2'b00;
    tick();
  endtask

  task automatic test_in_and_left();
    do_reset();
    for (int i = 0; i < 3; i++) admit(0);
    vehicle_arrival = 2'b01;
    tick();
    code_ack = 2'b01;
    tick();
    code_ack = 2'b00;
    vehicle_in = 1'b1;
    vehicle_left = 1'b1;
    tick();
    vehicle_in = 1'b0;
    vehicle_left = 1'b0;
    vehicle_arrival = 2'b00;
    checks++;
    if (occupancy !== 4'd3 || gate_open !== 1'b0) begin
      failures++;
      $display("FAIL in_and_left: got occ=%0d gate=%b want 3/0", occupancy, gate_open);
    end
    // vehicle_in outside OPEN is ignored.
    vehicle_in = 1'b1;
    tick();
    vehicle_in = 1'b0;
    checks++;
    if (occupancy !== 4'd3) begin
      failures++;
      $display("FAIL in_outside_open: got occ=%0d want 3", occupancy);
    end
    do_reset();
    vehicle_left = 1'b1;
    tick();
    vehicle_left = 1'b0;
    checks++;
    if (occupancy !== 4'd0) begin
      failures++;
      $display("FAIL left_at_zero: got occ=%0d want 0", occupancy);
    end
  endtask

  task automatic test_reset_in_open();
    do_reset();
    for (int i = 0; i < 5; i++) admit(0);
    vehicle_arrival = 2'b01;
    code0 = 16'h5990;
    code1 = 16'h5990;
    tick();
    code_ack = 2'b10;
    tick();
    code_ack = 2'b00;
    checks++;
    if (gate_open !== 1'b0 || wrong_pin !== 1'b0 || grant !== 2'b01) begin
      failures++;
      $display("FAIL other_ack_ignored: got gate=%b wp=%b grant=%b want 0/0/01", gate_open, wrong_pin, grant);
    end
    code_ack = 2'b01;
    tick();
    code_ack = 2'b00;
    checks++;
    if (gate_open !== 1'b1 || occupancy !== 4'd5) begin
      failures++;
      $display("FAIL pre_reset_open: got gate=%b occ=%0d want 1/5", gate_open, occupancy);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vehicle_arrival = 2'b00;
    checks++;
    if (gate_open !== 1'b0 || grant !== 2'b00 || occupancy !== 4'd0) begin
      failures++;
      $display("FAIL reset_in_open: got gate=%b grant=%b occ=%0d want 0/00/0", gate_open, grant, occupancy);
    end
    vehicle_arrival = 2'b11;
    tick();
    checks++;
    if (grant !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_idle: got grant=%b want 01", grant);
    end
    vehicle_arrival = 2'b00;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_entry();
    test_round_robin();
    test_block();
    test_drop();
    test_full();
    test_in_and_left();
    test_reset_in_open();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
